// File: rtl/pipe_stall_sequencer_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM encodings, stall causes
// and the fixed priority used to pick one cause per cycle.
package pipe_stall_sequencer_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_REQ  = 2'd1,
    D_RSP  = 2'd2
  } dmem_state_t;

  typedef enum logic [1:0] {
    I_IDLE = 2'd0,
    I_WAIT = 2'd1,
    I_DROP = 2'd2
  } imem_state_t;

  typedef enum logic [2:0] {
    CAUSE_MEM      = 3'd0,
    CAUSE_REDIRECT = 3'd1,
    CAUSE_LOAD_USE = 3'd2,
    CAUSE_FETCH    = 3'd3,
    CAUSE_NONE     = 3'd4
  } cause_t;

  // A memory stall freezes E, so a mispredict there must wait to be re-presented.
  function automatic cause_t pick_cause(input logic mem_stall, input logic mispre,
                                        input logic lw_hazard, input logic fetch_ok);
    if (mem_stall)      return CAUSE_MEM;
    else if (mispre)    return CAUSE_REDIRECT;
    else if (lw_hazard) return CAUSE_LOAD_USE;
    else if (!fetch_ok) return CAUSE_FETCH;
    else                return CAUSE_NONE;
  endfunction

  function automatic logic is_stall_cause(input cause_t cause);
    return (cause == CAUSE_MEM) || (cause == CAUSE_LOAD_USE) || (cause == CAUSE_FETCH);
  endfunction

endpackage

// File: rtl/pipe_stall_sequencer_dmem_hs_fsm.sv
// Data-memory handshake tracker for the M stage: reports when the current
// load/store has finished and whether M must be held.
module dmem_hs_fsm
  import pipe_stall_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic m_mem,
  input  logic m_load,
  input  logic gnt,
  input  logic rvalid,
  output logic done,
  output logic mem_stall,
  output logic dmem_req
);

  dmem_state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= D_IDLE;
    end else begin
      case (state)
        D_IDLE: if (m_mem) state <= gnt ? (m_load ? D_RSP : D_IDLE) : D_REQ;
        D_REQ:  if (gnt)   state <= m_load ? D_RSP : D_IDLE;
        D_RSP:  if (rvalid) state <= D_IDLE;
        default: state <= D_IDLE;
      endcase
    end
  end

  // A store completes on its grant; a load only once its data returns.
  always_comb begin
    done = 1'b0;
    case (state)
      D_IDLE, D_REQ: done = m_mem && gnt && !m_load;
      D_RSP:         done = rvalid;
      default:       done = 1'b0;
    endcase
  end

  assign mem_stall = m_mem && !done;
  assign dmem_req  = m_mem && (state != D_RSP);

endmodule

// File: rtl/pipe_stall_sequencer.sv
// Central stall/flush scheduler for the 5-stage pipeline: merges hazard requests with
// the imem/dmem handshakes into register enables, flushes, PC control and a stall counter.
module pipe_stall_sequencer
  import pipe_stall_sequencer_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lw_hazard_i,
  input  logic             mispre_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  input  logic             m_mem_i,
  input  logic             m_load_i,
  input  logic             dmem_gnt_i,
  input  logic             dmem_rvalid_i,
  input  logic             imem_ready_i,
  input  logic             imem_rvalid_i,
  output logic             imem_req_o,
  output logic             dmem_req_o,
  output logic             pc_en_o,
  output logic             pc_redirect_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             fd_en_o,
  output logic             de_en_o,
  output logic             em_en_o,
  output logic             fd_flush_o,
  output logic             de_flush_o,
  output logic             mw_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  imem_state_t istate;
  cause_t      cause;
  logic        dmem_done;
  logic        mem_stall;
  logic        dmem_req_raw;
  logic        fetch_ok;
  logic        stall_cycle;

  dmem_hs_fsm u_dmem (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_mem     (m_mem_i),
    .m_load    (m_load_i),
    .gnt       (dmem_gnt_i),
    .rvalid    (dmem_rvalid_i),
    .done      (dmem_done),
    .mem_stall (mem_stall),
    .dmem_req  (dmem_req_raw)
  );

  assign fetch_ok   = (istate == I_WAIT) && imem_rvalid_i;
  assign cause      = pick_cause(mem_stall, mispre_i, lw_hazard_i, fetch_ok);
  assign imem_req_o = (istate == I_IDLE);
  assign dmem_req_o = rst_n && dmem_req_raw;

  // While reset is held every control output stays at its idle value.
  always_comb begin
    pc_en_o       = 1'b0;
    pc_redirect_o = 1'b0;
    redirect_pc_o = '0;
    fd_en_o       = 1'b0;
    de_en_o       = 1'b0;
    em_en_o       = 1'b0;
    fd_flush_o    = 1'b0;
    de_flush_o    = 1'b0;
    mw_flush_o    = 1'b0;
    stall_cycle   = 1'b0;
    if (rst_n) begin
      stall_cycle = is_stall_cause(cause);
      case (cause)
        CAUSE_MEM: begin
          mw_flush_o = 1'b1;
        end
        CAUSE_REDIRECT: begin
          pc_en_o       = 1'b1;
          pc_redirect_o = 1'b1;
          redirect_pc_o = redirect_pc_i;
          fd_en_o       = 1'b1;
          de_en_o       = 1'b1;
          em_en_o       = 1'b1;
          fd_flush_o    = 1'b1;
          de_flush_o    = 1'b1;
        end
        CAUSE_LOAD_USE: begin
          de_en_o    = 1'b1;
          em_en_o    = 1'b1;
          de_flush_o = 1'b1;
        end
        CAUSE_FETCH: begin
          fd_en_o    = 1'b1;
          de_en_o    = 1'b1;
          em_en_o    = 1'b1;
          fd_flush_o = 1'b1;
        end
        default: begin
          pc_en_o = 1'b1;
          fd_en_o = 1'b1;
          de_en_o = 1'b1;
          em_en_o = 1'b1;
        end
      endcase
    end
  end

  // Fetch data arriving after a redirect belongs to the wrong path and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      istate <= I_IDLE;
    end else begin
      case (istate)
        I_IDLE: if (imem_ready_i) istate <= pc_redirect_o ? I_DROP : I_WAIT;
        I_WAIT: begin
          if (pc_redirect_o)                istate <= imem_rvalid_i ? I_IDLE : I_DROP;
          else if (imem_rvalid_i && fd_en_o) istate <= I_IDLE;
        end
        I_DROP: if (imem_rvalid_i) istate <= I_IDLE;
        default: istate <= I_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if (stall_cycle && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

  logic unused_done;
  assign unused_done = dmem_done;

endmodule

// File: tb/tb_pipe_stall_sequencer.sv
// Self-checking bench for pipe_stall_sequencer: directed scenarios plus randomized
// traffic compared against a transaction-level model of the stall rules.
module tb_pipe_stall_sequencer;
  localparam int XLEN    = 32;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lw_hazard = 1'b0, mispre = 1'b0, m_mem = 1'b0, m_load = 1'b0;
  logic dmem_gnt = 1'b0, dmem_rvalid = 1'b0, imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [XLEN-1:0] redirect_pc_in = '0;
  logic imem_req, dmem_req, pc_en, pc_redirect, fd_en, de_en, em_en;
  logic fd_flush, de_flush, mw_flush;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] stall_cnt;
  logic [9:0] out_vec;

  int errors = 0;
  int checks = 0;

  // Model state: fetch outstanding / fetch is wrong-path / load awaiting data.
  logic f_out, f_junk, ld_wait;
  int   exp_cnt;
  logic m_done, m_stall, m_redir, m_stalled, m_fd_en;
  logic [9:0]      exp_vec;
  logic [XLEN-1:0] exp_rpc;

  always #5 clk = ~clk;

  pipe_stall_sequencer #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .lw_hazard_i(lw_hazard), .mispre_i(mispre), .redirect_pc_i(redirect_pc_in),
    .m_mem_i(m_mem), .m_load_i(m_load), .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid),
    .imem_ready_i(imem_ready), .imem_rvalid_i(imem_rvalid),
    .imem_req_o(imem_req), .dmem_req_o(dmem_req), .pc_en_o(pc_en), .pc_redirect_o(pc_redirect),
    .redirect_pc_o(redirect_pc), .fd_en_o(fd_en), .de_en_o(de_en), .em_en_o(em_en),
    .fd_flush_o(fd_flush), .de_flush_o(de_flush), .mw_flush_o(mw_flush), .stall_cnt_o(stall_cnt)
  );

  assign out_vec = {imem_req, dmem_req, pc_en, pc_redirect, fd_en, de_en, em_en,
                    fd_flush, de_flush, mw_flush};

  task automatic model_reset();
    f_out = 1'b0; f_junk = 1'b0; ld_wait = 1'b0; exp_cnt = 0;
  endtask

  task automatic model_eval();
    logic fok;
    m_done  = ld_wait ? dmem_rvalid : (m_mem && dmem_gnt && !m_load);
    m_stall = m_mem && !m_done;
    fok     = f_out && !f_junk && imem_rvalid;
    m_redir = !m_stall && mispre;
    m_fd_en = !m_stall && (mispre || !lw_hazard);
    exp_vec = {!f_out, m_mem && !ld_wait,
               m_redir || (!m_stall && !mispre && !lw_hazard && fok), m_redir,
               m_fd_en, !m_stall, !m_stall,
               !m_stall && (mispre || (!lw_hazard && !fok)),
               !m_stall && (mispre || lw_hazard), m_stall};
    exp_rpc   = m_redir ? redirect_pc_in : '0;
    m_stalled = m_stall || (!mispre && (lw_hazard || !fok));
  endtask

  task automatic model_advance();
    if (ld_wait) begin
      if (dmem_rvalid) ld_wait = 1'b0;
    end else if (m_mem && dmem_gnt && m_load) begin
      ld_wait = 1'b1;
    end
    if (!f_out) begin
      if (imem_ready) begin f_out = 1'b1; f_junk = m_redir; end
    end else if (f_junk) begin
      if (imem_rvalid) f_out = 1'b0;
    end else if (m_redir) begin
      if (imem_rvalid) f_out = 1'b0; else f_junk = 1'b1;
    end else if (imem_rvalid && m_fd_en) begin
      f_out = 1'b0;
    end
    if (m_stalled && exp_cnt < CNT_MAX) exp_cnt++;
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    lw_hazard = 1'b0; mispre = 1'b0; m_mem = 1'b0; m_load = 1'b0; dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; redirect_pc_in = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic go_wait();
    imem_ready = 1'b1;
    sample();
    advance();
    imem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_mem = 1'b1; mispre = 1'b1; lw_hazard = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_vec !== 10'b1000000000) begin
      errors++; $display("[TB] FAIL reset_outputs: got %b expected %b", out_vec, 10'b1000000000);
    end
    checks++;
    if (stall_cnt !== '0 || redirect_pc !== '0) begin
      errors++; $display("[TB] FAIL reset_cnt_pc: got cnt=%0d pc=%h expected 0/0", stall_cnt, redirect_pc);
    end
    do_reset();
    sample();
    checks++;
    if (out_vec !== 10'b1000111100) begin
      errors++; $display("[TB] FAIL first_cycle: got %b expected %b", out_vec, 10'b1000111100);
    end
    advance();
    sample();
    checks++;
    if (stall_cnt !== CNT_W'(1)) begin
      errors++; $display("[TB] FAIL first_cycle_cnt: got %0d expected 1", stall_cnt);
    end
    advance();
  endtask

  task automatic test_store_delayed_gnt();
    int c0;
    do_reset();
    go_wait();
    m_mem = 1'b1; m_load = 1'b0;
    c0 = 0;
    for (int i = 0; i < 2; i++) begin
      sample();
      if (i == 0) c0 = int'(stall_cnt);
      checks++;
      if ({em_en, mw_flush, dmem_req, pc_en} !== 4'b0110) begin
        errors++; $display("[TB] FAIL store_stall%0d: got em/mw/req/pc=%b expected 0110", i,
                           {em_en, mw_flush, dmem_req, pc_en});
      end
      advance();
    end
    dmem_gnt = 1'b1;
    sample();
    checks++;
    if ({em_en, mw_flush} !== 2'b10) begin
      errors++; $display("[TB] FAIL store_done: got em/mw=%b expected 10", {em_en, mw_flush});
    end
    checks++;
    if (int'(stall_cnt) != c0 + 2) begin
      errors++; $display("[TB] FAIL store_cnt: got %0d expected %0d", stall_cnt, c0 + 2);
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_load_rvalid_late();
    int frozen;
    do_reset();
    go_wait();
    m_mem = 1'b1; m_load = 1'b1; dmem_gnt = 1'b1;
    frozen = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) dmem_gnt = 1'b0;
      if (i == 3) dmem_rvalid = 1'b1;
      sample();
      if (!em_en) frozen++;
      if (i < 3) begin
        checks++;
        if (dmem_req !== (i == 0)) begin
          errors++; $display("[TB] FAIL load_req%0d: got %b expected %b", i, dmem_req, i == 0);
        end
      end else begin
        checks++;
        if ({em_en, mw_flush} !== 2'b10) begin
          errors++; $display("[TB] FAIL load_release: got em/mw=%b expected 10", {em_en, mw_flush});
        end
      end
      advance();
    end
    checks++;
    if (frozen != 3) begin
      errors++; $display("[TB] FAIL load_frozen: got %0d cycles expected 3", frozen);
    end
    clear_inputs();
  endtask

  task automatic test_lw_hazard();
    do_reset();
    go_wait();
    imem_rvalid = 1'b1; lw_hazard = 1'b1;
    sample();
    checks++;
    if ({pc_en, fd_en, de_flush, em_en, de_en} !== 5'b00111) begin
      errors++; $display("[TB] FAIL lw_bubble: got %b expected 00111", {pc_en, fd_en, de_flush, em_en, de_en});
    end
    advance();
    lw_hazard = 1'b0;
    sample();
    checks++;
    if ({pc_en, fd_en, de_en, em_en, fd_flush, de_flush, mw_flush} !== 7'b1111000) begin
      errors++; $display("[TB] FAIL lw_resume: got %b expected 1111000",
                         {pc_en, fd_en, de_en, em_en, fd_flush, de_flush, mw_flush});
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_mispredict_drop();
    do_reset();
    go_wait();
    mispre = 1'b1; redirect_pc_in = 32'h0000_0100;
    sample();
    checks++;
    if ({pc_en, pc_redirect, fd_flush, de_flush, imem_req} !== 5'b11110) begin
      errors++; $display("[TB] FAIL redirect_ctrl: got %b expected 11110",
                         {pc_en, pc_redirect, fd_flush, de_flush, imem_req});
    end
    checks++;
    if (redirect_pc !== 32'h0000_0100) begin
      errors++; $display("[TB] FAIL redirect_pc: got %h expected 00000100", redirect_pc);
    end
    advance();
    mispre = 1'b0; redirect_pc_in = '0;
    for (int i = 0; i < 2; i++) begin
      imem_rvalid = (i == 1);
      sample();
      checks++;
      if ({imem_req, fd_flush, pc_en} !== 3'b010) begin
        errors++; $display("[TB] FAIL drop%0d: got req/fdfl/pc=%b expected 010", i, {imem_req, fd_flush, pc_en});
      end
      advance();
    end
    imem_rvalid = 1'b0;
    sample();
    checks++;
    if (imem_req !== 1'b1) begin
      errors++; $display("[TB] FAIL refetch_req: got %b expected 1", imem_req);
    end
    advance();
  endtask

  task automatic test_mispre_under_stall();
    do_reset();
    go_wait();
    m_mem = 1'b1; m_load = 1'b0; mispre = 1'b1; redirect_pc_in = 32'h0000_02A4;
    for (int i = 0; i < 2; i++) begin
      sample();
      checks++;
      if ({pc_redirect, pc_en, mw_flush} !== 3'b001 || redirect_pc !== '0) begin
        errors++; $display("[TB] FAIL held_redirect%0d: got %b pc=%h expected 001 pc=0", i,
                           {pc_redirect, pc_en, mw_flush}, redirect_pc);
      end
      advance();
    end
    dmem_gnt = 1'b1;
    sample();
    checks++;
    if ({pc_redirect, pc_en, mw_flush} !== 3'b110 || redirect_pc !== 32'h0000_02A4) begin
      errors++; $display("[TB] FAIL late_redirect: got %b pc=%h expected 110 pc=000002a4",
                         {pc_redirect, pc_en, mw_flush}, redirect_pc);
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_saturation_and_async_reset();
    int expv;
    do_reset();
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      sample();
      if (i >= CNT_MAX - 1) begin
        expv = (i < CNT_MAX) ? i : CNT_MAX;
        checks++;
        if (int'(stall_cnt) != expv) begin
          errors++; $display("[TB] FAIL saturate%0d: got %0d expected %0d", i, stall_cnt, expv);
        end
      end
      advance();
    end
    m_mem = 1'b1; m_load = 1'b1; dmem_gnt = 1'b1;
    sample();
    advance();
    dmem_gnt = 1'b0;
    sample();
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++; $display("[TB] FAIL in_rsp_req: got %b expected 0", dmem_req);
    end
    #1 rst_n = 1'b0; mispre = 1'b1;
    #1;
    checks++;
    if (out_vec !== 10'b1000000000 || stall_cnt !== '0) begin
      errors++; $display("[TB] FAIL async_reset: got %b cnt=%0d expected 1000000000 cnt=0", out_vec, stall_cnt);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++; $display("[TB] FAIL post_reset_dmem_idle: got %b expected 1", dmem_req);
    end
    clear_inputs();
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic busy;
    do_reset();
    busy = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      lw_hazard      = ($urandom_range(0, 99) < 15);
      mispre         = ($urandom_range(0, 99) < 15);
      redirect_pc_in = $urandom() & 32'hFFFF_FFFC;
      imem_ready     = ($urandom_range(0, 1) == 1);
      imem_rvalid    = f_out && ($urandom_range(0, 99) < 60);
      if (!busy && $urandom_range(0, 99) < 35) begin
        busy = 1'b1;
        m_load = ($urandom_range(0, 1) == 1);
      end
      m_mem       = busy;
      dmem_gnt    = ($urandom_range(0, 99) < 50);
      dmem_rvalid = ($urandom_range(0, 99) < 40);
      sample();
      checks++;
      if (out_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL rand_ctrl@%0d: got %b expected %b", n, out_vec, exp_vec);
      end
      checks++;
      if (redirect_pc !== exp_rpc) begin
        errors++; $display("[TB] FAIL rand_pc@%0d: got %h expected %h", n, redirect_pc, exp_rpc);
      end
      checks++;
      if (int'(stall_cnt) != exp_cnt) begin
        errors++; $display("[TB] FAIL rand_cnt@%0d: got %0d expected %0d", n, stall_cnt, exp_cnt);
      end
      if (m_done) busy = 1'b0;
      advance();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_store_delayed_gnt();
    test_load_rvalid_late();
    test_lw_hazard();
    test_mispredict_drop();
    test_mispre_under_stall();
    test_saturation_and_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not reach the end within 500000 time units");
    $fatal(1, "[TB] timeout");
  end

endmodule
